uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter between two requesters:
  - register-readout responses, one byte each, from the command path;
  - algorithm event packets built from rr_period, mas_valid and mal_valid.
- Buffers events in a small FIFO and frames each one as an atomic multi-byte packet.
- Gives register responses fixed priority at packet boundaries.
- Drives the transmitter's tx_data_valid/tx_data handshake and obeys tx_busy.

Parameters:
- EVT_FIFO_DEPTH, 4, number of queued event entries; power of two, at least 2.
- RR_W, 11, rr_period width in bits; fixed by the algorithm output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- rd_resp_valid  in  1  register response byte available
- rd_resp_data  in  8  register response byte
- rd_resp_ready  out  1  response accepted this cycle
- evt_valid  in  1  one-cycle pulse: new algorithm result
- rr_period  in  RR_W  RR interval, sampled on evt_valid
- mas_valid  in  1  flag, sampled on evt_valid
- mal_valid  in  1  flag, sampled on evt_valid
- alg_active  in  1  events accepted only while high
- evt_flush  in  1  synchronous FIFO clear
- ovf_clr  in  1  clears evt_ovf
- tx_busy  in  1  transmitter busy
- tx_data_valid  out  1  one-cycle byte launch strobe
- tx_data  out  8  byte to transmit
- evt_ovf  out  1  sticky: an event was dropped because the FIFO was full
- evt_level  out  $clog2(EVT_FIFO_DEPTH)+1  FIFO occupancy
- sched_busy  out  1  state != IDLE

Behaviour:
- Reset values: rd_resp_ready=0, tx_data_valid=0, tx_data=0, evt_ovf=0, evt_level=0, sched_busy=0.
- Async reset aborts any byte or packet in flight. The FIFO empties.
- Event push:
  - Condition: evt_valid & alg_active & !evt_flush.
  - Entry = {mas_valid, mal_valid, rr_period}.
  - If full with no pop in the same cycle: entry dropped and evt_ovf set.
  - Push and pop in the same cycle: level unchanged; allowed even when full.
- evt_flush empties the FIFO next cycle. A packet already popped completes. A push in the same cycle is dropped and does not set evt_ovf.
- evt_ovf: setting wins over ovf_clr in the same cycle.
- Transmitter contract: tx_busy rises the cycle after tx_data_valid and stays high until the stop bit ends.
- FSM states:
  - IDLE: arbitration only happens here, and only when tx_busy=0.
    - rd_resp_valid present: rd_resp_ready=1 (combinational), latch the byte, go to LAUNCH(src=REG).
    - Otherwise, FIFO not empty: pop, latch the entry, byte_idx=0, go to LAUNCH(src=EVT).
  - LAUNCH: tx_data_valid=1 for one cycle with the current byte, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: on tx_busy=0:
    - if src=EVT and more bytes remain: byte_idx++ and go to LAUNCH;
    - otherwise go to IDLE.
- Latency: accept at cycle N, tx_data_valid at N+1.
- Event packet format:
  - byte0 = {1'b1, mas, mal, 2'b00, rr[10:8]}
  - byte1 = rr[7:0]
- Register response bytes go out unmodified. The host tells them apart from packets by the command protocol.
- Atomicity: a register response is never inserted between the bytes of one packet. rd_resp_ready stays 0 until the packet completes.
- Starvation: responses have fixed priority over new packets. The FIFO absorbs bursts, and overflow is reported through evt_ovf.
- alg_active low: new events are ignored; queued entries still drain.

Optional Feature:
- Macro: UART_TX_PKT_CHK_EN.
- When defined: each event packet gets a third byte, byte2 = byte0 ^ byte1, sent atomically with the other two.
- When undefined: packets are 2 bytes and the checksum logic is absent.

Decomposition:
- Additions to uart_pkg:
  - uart_tx_sched_state_t enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE};
  - uart_tx_src_t enum {SRC_REG, SRC_EVT};
  - UART_EVT_HDR_BIT = 7;
  - UART_EVT_PKT_LEN (2, or 3 with the macro);
  - uart_evt_t packed struct {mas, mal, rr[10:0]}.
- Sub-module uart_evt_fifo: synchronous circular buffer parameterised by depth.
  - Push, pop and flush inputs; full, empty and level outputs.
  - Head/tail pointers one bit wider than the address for wrap-around detection.

Test Plan:
- Register only: rd_resp_valid with 0x5A, tx_busy model at 10 cycles.
  - Expect rd_resp_ready at N, tx_data_valid with 0x5A at N+1, and return to IDLE after tx_busy falls.
- Single event: rr_period=0x2A7, mas=1, mal=0.
  - Expect bytes 0xC2 then 0xA7, back-to-back, each launched only after tx_busy drops.
  - With UART_TX_PKT_CHK_EN: third byte 0x65.
- Collision: during event byte0, assert rd_resp_valid with 0x11.
  - rd_resp_ready stays 0 until byte1 finishes; then 0x11 is sent.
  - Both requests pending in IDLE: 0x11 goes first.
- Overflow: 5 events while the transmitter is stalled busy, depth 4.
  - evt_level=4, evt_ovf=1; after draining, exactly 4 packets are sent.
  - ovf_clr and a new overflow in the same cycle: evt_ovf stays 1.
- Flush and gating:
  - evt_flush mid-packet with 3 queued: the current packet completes, evt_level goes to 0, nothing more is sent.
  - evt_valid with alg_active=0: ignored.
- Reset mid-byte: deassert rst_n during WAIT_DONE.
  - All outputs go to reset values immediately; no further tx_data_valid until a new request.

Source files
------------

// File: rtl/uart_pkg.sv
// +---------------------------------------------------------------------------+
// | uart_pkg: shared types and helpers for the UART transmit scheduler.       |
// | Optional macro UART_TX_PKT_CHK_EN adds a checksum byte to event packets.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_tx_sched_state_t;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_EVT = 1'b1
  } uart_tx_src_t;

  localparam int UART_EVT_HDR_BIT = 7;
  localparam int UART_RR_W        = 11;

`ifdef UART_TX_PKT_CHK_EN
  localparam int UART_EVT_PKT_LEN = 3;
`else
  localparam int UART_EVT_PKT_LEN = 2;
`endif

  typedef struct packed {
    logic                 mas;
    logic                 mal;
    logic [UART_RR_W-1:0] rr;
  } uart_evt_t;

  // Byte idx of the packet framing one event; the header bit marks byte0.
  function automatic logic [7:0] uart_evt_byte(input uart_evt_t evt, input logic [1:0] idx);
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] res;
    b0 = {1'b0, evt.mas, evt.mal, 2'b00, evt.rr[10:8]};
    b0[UART_EVT_HDR_BIT] = 1'b1;
    b1 = evt.rr[7:0];
    case (idx)
      2'd0:    res = b0;
      2'd1:    res = b1;
`ifdef UART_TX_PKT_CHK_EN
      2'd2:    res = b0 ^ b1;
`endif
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_evt_fifo.sv
// +---------------------------------------------------------------------------+
// | uart_evt_fifo: synchronous circular buffer for queued algorithm events.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_wr_data,
  output logic [W-1:0]             o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int           AW         = $clog2(DEPTH);
  localparam logic [AW:0]  C_FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]  C_ONE      = (AW+1)'(1);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_level == C_FULL_LVL);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot the simultaneous push needs, so full is no obstacle then.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// +---------------------------------------------------------------------------+
// | uart_tx_scheduler: shares one UART transmitter between register responses |
// | and framed algorithm event packets. Macro UART_TX_PKT_CHK_EN adds byte2.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int EVT_FIFO_DEPTH = 4,
  parameter int RR_W           = 11
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rd_resp_valid,
  input  logic [7:0]                        rd_resp_data,
  output logic                              rd_resp_ready,
  input  logic                              evt_valid,
  input  logic [RR_W-1:0]                   rr_period,
  input  logic                              mas_valid,
  input  logic                              mal_valid,
  input  logic                              alg_active,
  input  logic                              evt_flush,
  input  logic                              ovf_clr,
  input  logic                              tx_busy,
  output logic                              tx_data_valid,
  output logic [7:0]                        tx_data,
  output logic                              evt_ovf,
  output logic [$clog2(EVT_FIFO_DEPTH):0]   evt_level,
  output logic                              sched_busy
);

  localparam logic [1:0] C_LAST_IDX = 2'(UART_EVT_PKT_LEN - 1);

  uart_tx_sched_state_t r_state;
  uart_tx_src_t         r_src;
  uart_evt_t            r_evt;
  logic [1:0]           r_byte_idx;
  logic                 r_tx_valid;
  logic [7:0]           r_tx_data;
  logic                 r_ovf;

  uart_evt_t            w_entry_in;
  uart_evt_t            w_evt_out;
  logic                 w_push_req;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_arb;
  logic                 w_reg_go;
  logic                 w_evt_go;
  logic                 w_drop;

  assign w_entry_in = '{mas: mas_valid, mal: mal_valid, rr: rr_period};
  assign w_push_req = evt_valid && alg_active && !evt_flush;
  assign w_arb      = (r_state == IDLE) && !tx_busy;
  assign w_reg_go   = w_arb && rd_resp_valid;
  assign w_evt_go   = w_arb && !rd_resp_valid && !w_fifo_empty && !evt_flush;
  assign w_drop     = w_push_req && w_fifo_full && !w_evt_go;

  assign rd_resp_ready = w_reg_go;
  assign tx_data_valid = r_tx_valid;
  assign tx_data       = r_tx_data;
  assign evt_ovf       = r_ovf;
  assign sched_busy    = (r_state != IDLE);

  uart_evt_fifo #(
    .DEPTH (EVT_FIFO_DEPTH),
    .W     ($bits(uart_evt_t))
  ) u_evt_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push_req),
    .i_pop     (w_evt_go),
    .i_flush   (evt_flush),
    .i_wr_data (w_entry_in),
    .o_rd_data (w_evt_out),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_level   (evt_level)
  );

  // Arbitration only in IDLE, so a packet's bytes are never split by a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_src      <= SRC_REG;
      r_evt      <= '0;
      r_byte_idx <= 2'd0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_reg_go) begin
            r_src      <= SRC_REG;
            r_tx_data  <= rd_resp_data;
            r_tx_valid <= 1'b1;
            r_state    <= LAUNCH;
          end else if (w_evt_go) begin
            r_src      <= SRC_EVT;
            r_evt      <= w_evt_out;
            r_byte_idx <= 2'd0;
            r_tx_data  <= uart_evt_byte(w_evt_out, 2'd0);
            r_tx_valid <= 1'b1;
            r_state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_tx_valid <= 1'b0;
          r_state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (r_src == SRC_EVT && r_byte_idx != C_LAST_IDX) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_tx_data  <= uart_evt_byte(r_evt, r_byte_idx + 2'd1);
              r_tx_valid <= 1'b1;
              r_state    <= LAUNCH;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// +---------------------------------------------------------------------------+
// | tb_uart_tx_scheduler: randomized self-checking bench with a transmitter   |
// | model and a packet-level reference. Revision: 1.0                         |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int DEPTH    = 4;
  localparam int RR_W     = 11;
  localparam int BUSY_CYC = 10;
`ifdef UART_TX_PKT_CHK_EN
  localparam int PKT_LEN = 3;
`else
  localparam int PKT_LEN = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rd_resp_valid, rd_resp_ready;
  logic [7:0]      rd_resp_data;
  logic            evt_valid, mas_valid, mal_valid, alg_active, evt_flush, ovf_clr;
  logic [RR_W-1:0] rr_period;
  logic            tx_busy, tx_data_valid, evt_ovf, sched_busy;
  logic [7:0]      tx_data;
  logic [2:0]      evt_level;

  logic            m_busy = 1'b0;
  int              m_cnt  = 0;
  logic            stall;
  int              viol   = 0;
  logic [7:0]      sent_q[$];
  logic [7:0]      exp_q[$];
  int              errors = 0;
  int              checks = 0;

  assign tx_busy = m_busy | stall;

  uart_tx_scheduler #(.EVT_FIFO_DEPTH(DEPTH), .RR_W(RR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_ready(rd_resp_ready),
    .evt_valid(evt_valid), .rr_period(rr_period), .mas_valid(mas_valid), .mal_valid(mal_valid),
    .alg_active(alg_active), .evt_flush(evt_flush), .ovf_clr(ovf_clr),
    .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .evt_ovf(evt_ovf), .evt_level(evt_level), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  // Transmitter: busy from the cycle after a launch for BUSY_CYC cycles.
  always @(posedge clk) begin
    if (tx_data_valid) begin
      if (tx_busy) viol <= viol + 1;
      sent_q.push_back(tx_data);
      m_busy <= 1'b1;
      m_cnt  <= BUSY_CYC;
    end else if (m_busy) begin
      if (m_cnt <= 1) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  // Reference packet framing from the packet format rules.
  task automatic exp_evt(input logic [12:0] e);
    int hdr, lo;
    hdr = 128 + (e[12] ? 64 : 0) + (e[11] ? 32 : 0) + int'(e[10:0]) / 256;
    lo  = int'(e[10:0]) % 256;
    exp_q.push_back(8'(hdr));
    exp_q.push_back(8'(lo));
    if (PKT_LEN == 3) exp_q.push_back(8'(hdr ^ lo));
  endtask

  function automatic int count_diff();
    int bad = 0;
    if (sent_q.size() != exp_q.size()) return -1;
    foreach (exp_q[i]) if (sent_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic push_evt(input logic [12:0] e);
    @(negedge clk);
    evt_valid = 1'b1; {mas_valid, mal_valid, rr_period} = e;
    @(negedge clk);
    evt_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int q = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!sched_busy && !tx_busy && evt_level == 3'd0 && !tx_data_valid) q++;
      else q = 0;
      if (q >= 3) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 6;
    if (rd_resp_ready !== 1'b0) begin errors++; $display("FAIL reset rd_resp_ready got %b want 0", rd_resp_ready); end
    if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset tx_data_valid got %b want 0", tx_data_valid); end
    if (tx_data !== 8'h00)      begin errors++; $display("FAIL reset tx_data got %h want 00", tx_data); end
    if (evt_ovf !== 1'b0)       begin errors++; $display("FAIL reset evt_ovf got %b want 0", evt_ovf); end
    if (evt_level !== 3'd0)     begin errors++; $display("FAIL reset evt_level got %0d want 0", evt_level); end
    if (sched_busy !== 1'b0)    begin errors++; $display("FAIL reset sched_busy got %b want 0", sched_busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_register;
    logic [7:0] b;
    bit ok;
    int d;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h5A : 8'($urandom);
      sent_q.delete();
      @(negedge clk);
      rd_resp_valid = 1'b1; rd_resp_data = b;
      #1;
      checks++;
      if (rd_resp_ready !== 1'b1) begin errors++; $display("FAIL reg_ready got %b want 1", rd_resp_ready); end
      @(negedge clk);
      rd_resp_valid = 1'b0;
      checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== b) begin
        errors++; $display("FAIL reg_launch got v=%b d=%h want v=1 d=%h", tx_data_valid, tx_data, b);
      end
      @(negedge clk);
      checks++;
      if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reg_strobe_width got %b want 0", tx_data_valid); end
      wait_quiet(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reg_idle timeout got busy want idle"); end
      exp_q.delete(); exp_q.push_back(b);
      d = count_diff();
      checks++;
      if (d != 0) begin errors++; $display("FAIL reg_bytes got %0d bytes diff=%0d want 1 byte %h", sent_q.size(), d, b); end
    end
  endtask

  task automatic test_single_event;
    logic [12:0] e;
    bit ok;
    int d;
    for (int k = 0; k < 4; k++) begin
      e = (k == 0) ? {1'b1, 1'b0, 11'h2A7} : 13'($urandom);
      sent_q.delete(); exp_q.delete();
      push_evt(e);
      exp_evt(e);
      wait_quiet(300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL evt_idle timeout got busy want idle"); end
      d = count_diff();
      checks++;
      if (d != 0) begin
        errors++;
        $display("FAIL evt_bytes got %0d bytes diff=%0d first=%h want %0d bytes first=%h",
                 sent_q.size(), d, (sent_q.size() > 0) ? sent_q[0] : 8'h00, exp_q.size(), exp_q[0]);
      end
      checks++;
      if (viol != 0) begin errors++; $display("FAIL evt_launch_while_busy got %0d want 0", viol); end
    end
  endtask

  task automatic test_collision;
    logic [12:0] e;
    bit ok, acc, seen;
    int nsent, d;
    // Response arrives while byte0 of a packet is in flight.
    e = 13'($urandom);
    sent_q.delete(); exp_q.delete();
    push_evt(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (tx_data_valid) seen = 1'b1; else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL coll_byte0 timeout got none want launch"); end
    rd_resp_valid = 1'b1; rd_resp_data = 8'h11;
    acc = 1'b0; nsent = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      #1;
      if (rd_resp_ready) begin acc = 1'b1; nsent = sent_q.size(); end
      else @(negedge clk);
    end
    @(negedge clk);
    rd_resp_valid = 1'b0;
    checks += 2;
    if (!acc) begin errors++; $display("FAIL coll_accept timeout got no ready want ready"); end
    if (nsent != PKT_LEN) begin errors++; $display("FAIL coll_atomic got %0d bytes sent at accept want %0d", nsent, PKT_LEN); end
    exp_evt(e); exp_q.push_back(8'h11);
    wait_quiet(400, ok);
    d = count_diff();
    checks++;
    if (!ok || d != 0) begin errors++; $display("FAIL coll_order got %0d bytes diff=%0d ok=%b want %0d", sent_q.size(), d, ok, exp_q.size()); end

    // Both pending in IDLE: the response goes first.
    e = 13'($urandom);
    sent_q.delete(); exp_q.delete();
    stall = 1'b1;
    push_evt(e);
    rd_resp_valid = 1'b1; rd_resp_data = 8'h11;
    checks++;
    if (evt_level !== 3'd1) begin errors++; $display("FAIL coll_level got %0d want 1", evt_level); end
    stall = 1'b0;
    acc = 1'b0; nsent = -1;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      if (rd_resp_ready) begin acc = 1'b1; nsent = sent_q.size(); end
      else @(negedge clk);
    end
    @(negedge clk);
    rd_resp_valid = 1'b0;
    checks++;
    if (!acc || nsent != 0) begin errors++; $display("FAIL coll_prio got acc=%b sent=%0d want acc=1 sent=0", acc, nsent); end
    exp_q.push_back(8'h11); exp_evt(e);
    wait_quiet(400, ok);
    d = count_diff();
    checks++;
    if (!ok || d != 0) begin errors++; $display("FAIL coll_prio_order got %0d bytes diff=%0d first=%h want 11 first", sent_q.size(), d, (sent_q.size() > 0) ? sent_q[0] : 8'h00); end
  endtask

  task automatic test_overflow;
    logic [12:0] ref_q[$];
    logic [12:0] e;
    logic        ovf;
    bit          ok;
    int          d;
    sent_q.delete(); exp_q.delete();
    ovf = 1'b0;
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = 13'($urandom);
      evt_valid = 1'b1; {mas_valid, mal_valid, rr_period} = e;
      if (ref_q.size() < DEPTH) ref_q.push_back(e); else ovf = 1'b1;
    end
    @(negedge clk);
    evt_valid = 1'b0;
    checks += 2;
    if (evt_level !== 3'(ref_q.size())) begin errors++; $display("FAIL ovf_level got %0d want %0d", evt_level, ref_q.size()); end
    if (evt_ovf !== ovf) begin errors++; $display("FAIL ovf_flag got %b want %b", evt_ovf, ovf); end
    // Clear and a fresh overflow in the same cycle: the set wins.
    evt_valid = 1'b1; ovf_clr = 1'b1; {mas_valid, mal_valid, rr_period} = 13'($urandom);
    @(negedge clk);
    evt_valid = 1'b0;
    checks++;
    if (evt_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", evt_ovf); end
    @(negedge clk);
    ovf_clr = 1'b0;
    checks += 2;
    if (evt_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", evt_ovf); end
    if (evt_level !== 3'(DEPTH)) begin errors++; $display("FAIL ovf_level_hold got %0d want %0d", evt_level, DEPTH); end
    stall = 1'b0;
    foreach (ref_q[i]) exp_evt(ref_q[i]);
    wait_quiet(2000, ok);
    d = count_diff();
    checks += 2;
    if (!ok || d != 0) begin errors++; $display("FAIL ovf_drain got %0d bytes diff=%0d ok=%b want %0d", sent_q.size(), d, ok, exp_q.size()); end
    if (viol != 0) begin errors++; $display("FAIL ovf_launch_while_busy got %0d want 0", viol); end
  endtask

  task automatic test_flush_gating;
    logic [12:0] ref_q[$];
    logic [12:0] e;
    bit ok, seen;
    int d;
    sent_q.delete(); exp_q.delete();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = 13'($urandom);
      evt_valid = 1'b1; {mas_valid, mal_valid, rr_period} = e;
      ref_q.push_back(e);
    end
    @(negedge clk);
    evt_valid = 1'b0;
    stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_data_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || evt_level !== 3'd3) begin errors++; $display("FAIL flush_pre got seen=%b level=%0d want 1/3", seen, evt_level); end
    evt_flush = 1'b1; evt_valid = 1'b1; {mas_valid, mal_valid, rr_period} = 13'($urandom);
    @(negedge clk);
    evt_flush = 1'b0; evt_valid = 1'b0;
    checks += 2;
    if (evt_level !== 3'd0) begin errors++; $display("FAIL flush_level got %0d want 0", evt_level); end
    if (evt_ovf !== 1'b0)   begin errors++; $display("FAIL flush_no_ovf got %b want 0", evt_ovf); end
    exp_evt(ref_q[0]);
    wait_quiet(400, ok);
    d = count_diff();
    checks++;
    if (!ok || d != 0) begin errors++; $display("FAIL flush_bytes got %0d bytes diff=%0d want %0d", sent_q.size(), d, exp_q.size()); end

    // Gating: ignored while alg_active is low.
    sent_q.delete();
    alg_active = 1'b0;
    push_evt(13'($urandom));
    checks++;
    if (evt_level !== 3'd0) begin errors++; $display("FAIL gate_level got %0d want 0", evt_level); end
    repeat (30) @(negedge clk);
    checks++;
    if (sent_q.size() != 0) begin errors++; $display("FAIL gate_sent got %0d bytes want 0", sent_q.size()); end

    // Queued entries still drain after alg_active drops.
    exp_q.delete();
    alg_active = 1'b1;
    stall = 1'b1;
    e = 13'($urandom);
    push_evt(e);
    alg_active = 1'b0;
    stall = 1'b0;
    exp_evt(e);
    wait_quiet(400, ok);
    d = count_diff();
    checks++;
    if (!ok || d != 0) begin errors++; $display("FAIL gate_drain got %0d bytes diff=%0d want %0d", sent_q.size(), d, exp_q.size()); end
    alg_active = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit ok, seen, acc;
    int d;
    sent_q.delete();
    push_evt(13'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_data_valid) seen = 1'b1;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!seen || sched_busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre got seen=%b busy=%b want 1/1", seen, sched_busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_data_valid !== 1'b0 || tx_data !== 8'h00 || evt_ovf !== 1'b0 ||
        evt_level !== 3'd0 || sched_busy !== 1'b0 || rd_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got v=%b d=%h ovf=%b lvl=%0d busy=%b rdy=%b want all 0",
               tx_data_valid, tx_data, evt_ovf, evt_level, sched_busy, rd_resp_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sent_q.delete();
    repeat (40) @(negedge clk);
    checks++;
    if (sent_q.size() != 0) begin errors++; $display("FAIL rstmid_quiet got %0d launches want 0", sent_q.size()); end
    rd_resp_valid = 1'b1; rd_resp_data = 8'h3C;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      if (rd_resp_ready) acc = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    rd_resp_valid = 1'b0;
    exp_q.delete(); exp_q.push_back(8'h3C);
    wait_quiet(200, ok);
    d = count_diff();
    checks++;
    if (!acc || !ok || d != 0) begin errors++; $display("FAIL rstmid_resume got acc=%b %0d bytes diff=%0d want 1 byte 3c", acc, sent_q.size(), d); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    rd_resp_valid = 1'b0; rd_resp_data = 8'h00;
    evt_valid = 1'b0; rr_period = '0; mas_valid = 1'b0; mal_valid = 1'b0;
    alg_active = 1'b1; evt_flush = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    repeat (2) @(negedge clk);
    test_register();
    test_single_event();
    test_collision();
    test_overflow();
    test_flush_gating();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
